// File: rtl/t03_wb_manager_pkg.sv
// Shared types and constants for the Wishbone manager slice.
package t03_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_t;

    localparam logic [31:0] T03_ERR_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/t03_wb_manager_if.sv
// Wishbone B4 classic bus between the manager (master) and the fabric (slave).
interface t03_wb_if;

    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );

endinterface

// File: rtl/t03_wb_manager_timeout.sv
// Bus-wait watchdog: loaded on entry to a bus cycle, counts down while enabled.
// expired is combinational and fires in the last permitted wait cycle.
module t03_wb_timeout #(
    parameter int CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = W'(CYCLES);
        end else if (enable && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count of 1 means this is the final allowed cycle; the decrement reaches 0 here.
    assign expired = enable && (cnt_q == W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/t03_wb_manager.sv
// Wishbone classic manager: level read/write request -> one CYC/STB cycle -> one-cycle ack (min 3 cycles).
// No backpressure beyond busy/ack; optional bus-wait abort when T03_WB_TIMEOUT_EN is defined.
module t03_wb_manager
    import t03_pkg::*;
#(
    parameter logic [31:0] ERR_DATA       = T03_ERR_DATA,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic [3:0]  sel,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        bus_error,
    t03_wb_if.master    wb
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    wb_state_t   state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] rdata_q, rdata_d;
    logic        bus_error_q, bus_error_d;
    logic        tmo_expired;

`ifdef T03_WB_TIMEOUT_EN
    logic tmo_load;
    assign tmo_load = (state_q == IDLE) && (read || write);

    t03_wb_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .load    (tmo_load),
        .enable  (state_q == BUS),
        .expired (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        rdata_d     = rdata_q;
        bus_error_d = bus_error_q;
        case (state_q)
            IDLE: begin
                if (read || write) begin
                    adr_d   = address;
                    dat_d   = wdata;
                    sel_d   = sel;
                    we_d    = write;
                    state_d = BUS;
                end
            end
            BUS: begin
                // ERR outranks a simultaneous ACK; the timeout is the lowest priority.
                if (wb.wb_err_i || (!wb.wb_ack_i && tmo_expired)) begin
                    rdata_d     = ERR_DATA;
                    bus_error_d = 1'b1;
                    state_d     = RESP;
                end else if (wb.wb_ack_i) begin
                    if (!we_q) begin
                        rdata_d = wb.wb_dat_i;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            rdata_q     <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            rdata_q     <= rdata_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign wb.wb_cyc_o = (state_q == BUS);
    assign wb.wb_stb_o = (state_q == BUS);
    assign wb.wb_we_o  = we_q;
    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_sel_o = sel_q;

    assign ack       = (state_q == RESP);
    assign busy      = (state_q == BUS) || (state_q == RESP);
    assign rdata     = rdata_q;
    assign bus_error = bus_error_q;

endmodule
